// File: rtl/ram_pkg.sv
// Shared constants and types for the parametrised true dual-port RAM.
package ram_pkg;

  // Per-port read-during-write behaviour on the port's own address.
  localparam int unsigned RDW_WRITE_FIRST = 0;
  localparam int unsigned RDW_READ_FIRST  = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  // Memory-clear state machine.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  // An accepted access refreshes q unless it is a write in no-change mode.
  function automatic logic rdw_updates(input int unsigned mode, input logic we);
    return !(we && (mode == RDW_NO_CHANGE));
  endfunction

endpackage

// File: rtl/ram_tdp_param_if.sv
// Bus bundle for both RAM ports plus the shared status outputs.
interface ram_tdp_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);

  logic              en_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] q_a;
  logic              valid_a;

  logic              en_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] q_b;
  logic              valid_b;

  logic              busy;
  logic              collision;

  modport master (
    output en_a, we_a, addr_a, data_a,
    output en_b, we_b, addr_b, data_b,
    input  q_a, valid_a, q_b, valid_b, busy, collision
  );

  modport slave (
    input  en_a, we_a, addr_a, data_a,
    input  en_b, we_b, addr_b, data_b,
    output q_a, valid_a, q_b, valid_b, busy, collision
  );

endinterface

// File: rtl/ram_tdp_port.sv
// One RAM port's read path: read-during-write selection, optional output
// pipeline stage and the matching valid strobe.
module ram_tdp_port
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RDW_MODE = RDW_WRITE_FIRST,
  parameter bit          OUT_REG  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              acc_i,      // accepted access this cycle
  input  logic              we_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] rd_old_i,   // array content before this edge
  output logic [DATA_W-1:0] q_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] q1_d, q1_q;
  logic              v1_d, v1_q;

  // First stage: pick new write data or old array content; hold otherwise.
  always_comb begin
    v1_d = acc_i && rdw_updates(RDW_MODE, we_i);
    q1_d = q1_q;
    if (v1_d) begin
      q1_d = (we_i && (RDW_MODE == RDW_WRITE_FIRST)) ? wr_data_i : rd_old_i;
    end
  end

  // First-stage registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      q1_q <= q1_d;
      v1_q <= v1_d;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_W-1:0] q2_d, q2_q;
    logic              v2_q;

    // Second stage only loads when the first stage produced a result.
    always_comb begin
      q2_d = v1_q ? q1_q : q2_q;
    end

    // Output pipeline registers.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        q2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        q2_q <= q2_d;
        v2_q <= v1_q;
      end
    end

    assign q_o     = q2_q;
    assign valid_o = v2_q;
  end else begin : g_no_out_reg
    assign q_o     = q1_q;
    assign valid_o = v1_q;
  end

endmodule

// File: rtl/ram_tdp_param.sv
// Parametrised true dual-port synchronous RAM with write-collision
// arbitration and a post-reset clear sequence.
module ram_tdp_param
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned RDW_MODE_A   = RDW_WRITE_FIRST,
  parameter int unsigned RDW_MODE_B   = RDW_WRITE_FIRST,
  parameter bit          WR_PRIO_A    = 1'b1,
  parameter bit          OUT_REG      = 1'b0,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input logic             clk,
  input logic             rst,
  ram_tdp_param_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  clr_state_e        state_d, state_q;
  logic [ADDR_W-1:0] clr_addr_d, clr_addr_q;
  logic              clr_we;
  logic              busy;

  logic              acc_a, acc_b, wr_a, wr_b;
  logic              mem_we_a, mem_we_b;
  logic              collision_d, collision_q;
  logic [DATA_W-1:0] rd_old_a, rd_old_b;

  assign busy = (state_q == ST_CLEAR);

  // Clear FSM: walk every address once, then stay in RUN until reset.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we     = ~rst;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
      end
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Access qualification and same-address write arbitration.
  always_comb begin
    acc_a       = bus.en_a & ~busy & ~rst;
    acc_b       = bus.en_b & ~busy & ~rst;
    wr_a        = acc_a & bus.we_a;
    wr_b        = acc_b & bus.we_b;
    collision_d = wr_a & wr_b & (bus.addr_a == bus.addr_b);
    mem_we_a    = wr_a & (~collision_d | WR_PRIO_A);
    mem_we_b    = wr_b & (~collision_d | ~WR_PRIO_A);
  end

  // Array writes; clearing and accesses are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= '0;
    end else begin
      if (mem_we_a) mem[bus.addr_a] <= bus.data_a;
      if (mem_we_b) mem[bus.addr_b] <= bus.data_b;
    end
  end

  // Collision flag is a single-cycle pulse after the conflicting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  // Pre-edge content gives read-first and cross-port old-data semantics.
  assign rd_old_a = mem[bus.addr_a];
  assign rd_old_b = mem[bus.addr_b];

  ram_tdp_port #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE_A),
    .OUT_REG  (OUT_REG)
  ) u_port_a (
    .clk_i     (clk),
    .rst_i     (rst),
    .acc_i     (acc_a),
    .we_i      (bus.we_a),
    .wr_data_i (bus.data_a),
    .rd_old_i  (rd_old_a),
    .q_o       (bus.q_a),
    .valid_o   (bus.valid_a)
  );

  ram_tdp_port #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE_B),
    .OUT_REG  (OUT_REG)
  ) u_port_b (
    .clk_i     (clk),
    .rst_i     (rst),
    .acc_i     (acc_b),
    .we_i      (bus.we_b),
    .wr_data_i (bus.data_b),
    .rd_old_i  (rd_old_b),
    .q_o       (bus.q_b),
    .valid_o   (bus.valid_b)
  );

  assign bus.busy      = busy;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_ram_tdp_param.sv
// Directed bench for ram_tdp_param using three differently configured DUTs.
module tb_ram_tdp_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt;
  logic anyv;

  always #5 clk = ~clk;

  ram_tdp_param_if #(.DATA_W(8), .ADDR_W(6)) bus0 ();
  ram_tdp_param_if #(.DATA_W(8), .ADDR_W(6)) bus1 ();
  ram_tdp_param_if #(.DATA_W(8), .ADDR_W(6)) bus2 ();

  // Defaults: write-first both ports, A wins, no output register, clear on reset.
  ram_tdp_param u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // Read-first both ports, B wins, output register.
  ram_tdp_param #(
    .RDW_MODE_A (1),
    .RDW_MODE_B (1),
    .WR_PRIO_A  (1'b0),
    .OUT_REG    (1'b1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // No-change on A, no clear after reset.
  ram_tdp_param #(
    .RDW_MODE_A   (2),
    .CLEAR_ON_RST (1'b0)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int idx, input bit port_b, input bit en, input bit we,
                     input logic [5:0] addr, input logic [7:0] data);
    case ({idx[1:0], port_b})
      3'b000: begin bus0.en_a = en; bus0.we_a = we; bus0.addr_a = addr; bus0.data_a = data; end
      3'b001: begin bus0.en_b = en; bus0.we_b = we; bus0.addr_b = addr; bus0.data_b = data; end
      3'b010: begin bus1.en_a = en; bus1.we_a = we; bus1.addr_a = addr; bus1.data_a = data; end
      3'b011: begin bus1.en_b = en; bus1.we_b = we; bus1.addr_b = addr; bus1.data_b = data; end
      3'b100: begin bus2.en_a = en; bus2.we_a = we; bus2.addr_a = addr; bus2.data_a = data; end
      default: begin bus2.en_b = en; bus2.we_b = we; bus2.addr_b = addr; bus2.data_b = data; end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      drv(i, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
      drv(i, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    end
  endtask

  initial begin
    idle_all();

    // Reset state
    tick();
    rst = 1'b0;
    check("rst_busy0", 32'(bus0.busy), 32'd1);
    check("rst_busy1", 32'(bus1.busy), 32'd1);
    check("rst_busy2_noclear", 32'(bus2.busy), 32'd0);
    check("rst_q_a0", 32'(bus0.q_a), 32'h00);
    check("rst_valid_a0", 32'(bus0.valid_a), 32'd0);
    check("rst_collision0", 32'(bus0.collision), 32'd0);

    // Clear length; reads issued while busy are ignored
    drv(0, 1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    cnt  = 0;
    anyv = 1'b0;
    while (bus0.busy && cnt < 200) begin
      tick();
      cnt++;
      anyv = anyv | bus0.valid_a;
    end
    idle_all();
    check("busy_cycles", 32'(cnt), 32'd64);
    check("busy_no_valid", 32'(anyv), 32'd0);
    check("busy1_done", 32'(bus1.busy), 32'd0);

    // Cleared reads at 0, 37, 63
    for (int k = 0; k < 3; k++) begin
      logic [5:0] a;
      a = (k == 0) ? 6'd0 : (k == 1) ? 6'd37 : 6'd63;
      drv(0, 1'b0, 1'b1, 1'b0, a, 8'h00);
      tick();
      check("clr_rd_valid", 32'(bus0.valid_a), 32'd1);
      check("clr_rd_q", 32'(bus0.q_a), 32'h00);
      drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
      tick();
      check("idle_no_valid", 32'(bus0.valid_a), 32'd0);
    end

    // Write-first on DUT0
    drv(0, 1'b0, 1'b1, 1'b1, 6'd10, 8'h5A);
    tick();
    check("wf_q", 32'(bus0.q_a), 32'h5A);
    check("wf_valid", 32'(bus0.valid_a), 32'd1);
    drv(0, 1'b0, 1'b1, 1'b0, 6'd10, 8'h00);
    tick();
    check("wf_readback", 32'(bus0.q_a), 32'h5A);
    idle_all();

    // Read-first with output register on DUT1
    drv(1, 1'b0, 1'b1, 1'b1, 6'd10, 8'h11);
    tick();
    idle_all();
    check("rf_lat1_no_valid", 32'(bus1.valid_a), 32'd0);
    tick();
    check("rf_first_valid", 32'(bus1.valid_a), 32'd1);
    check("rf_first_old", 32'(bus1.q_a), 32'h00);
    drv(1, 1'b0, 1'b1, 1'b1, 6'd10, 8'h5A);
    tick();
    idle_all();
    tick();
    check("rf_old_data", 32'(bus1.q_a), 32'h11);
    drv(1, 1'b0, 1'b1, 1'b0, 6'd10, 8'h00);
    tick();
    idle_all();
    tick();
    check("rf_readback", 32'(bus1.q_a), 32'h5A);

    // No-change on DUT2
    drv(2, 1'b0, 1'b1, 1'b1, 6'd10, 8'h33);
    tick();
    idle_all();
    check("nc_no_valid", 32'(bus2.valid_a), 32'd0);
    check("nc_q_hold_rst", 32'(bus2.q_a), 32'h00);
    drv(2, 1'b0, 1'b1, 1'b0, 6'd10, 8'h00);
    tick();
    idle_all();
    check("nc_rd_valid", 32'(bus2.valid_a), 32'd1);
    check("nc_rd_q", 32'(bus2.q_a), 32'h33);
    drv(2, 1'b0, 1'b1, 1'b1, 6'd10, 8'h5A);
    tick();
    idle_all();
    check("nc_wr_no_valid", 32'(bus2.valid_a), 32'd0);
    check("nc_wr_q_hold", 32'(bus2.q_a), 32'h33);
    drv(2, 1'b0, 1'b1, 1'b0, 6'd10, 8'h00);
    tick();
    idle_all();
    check("nc_readback", 32'(bus2.q_a), 32'h5A);

    // Cross-port write/read same address
    drv(0, 1'b1, 1'b1, 1'b1, 6'd20, 8'h07);
    tick();
    check("xp_setup", 32'(bus0.q_b), 32'h07);
    drv(0, 1'b0, 1'b1, 1'b1, 6'd20, 8'hC3);
    drv(0, 1'b1, 1'b1, 1'b0, 6'd20, 8'h00);
    tick();
    check("xp_reader_old", 32'(bus0.q_b), 32'h07);
    check("xp_writer_new", 32'(bus0.q_a), 32'hC3);
    check("xp_no_collision", 32'(bus0.collision), 32'd0);
    drv(0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    tick();
    check("xp_later_read", 32'(bus0.q_b), 32'hC3);
    idle_all();

    // Same-address dual write, A wins
    drv(0, 1'b0, 1'b1, 1'b1, 6'd5, 8'hAA);
    drv(0, 1'b1, 1'b1, 1'b1, 6'd5, 8'h55);
    tick();
    idle_all();
    check("col0_pulse", 32'(bus0.collision), 32'd1);
    check("col0_q_a_own", 32'(bus0.q_a), 32'hAA);
    check("col0_q_b_own", 32'(bus0.q_b), 32'h55);
    tick();
    check("col0_pulse_end", 32'(bus0.collision), 32'd0);
    drv(0, 1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    drv(0, 1'b1, 1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    idle_all();
    check("col0_stored_a", 32'(bus0.q_a), 32'hAA);
    check("col0_stored_b", 32'(bus0.q_b), 32'hAA);
    check("dual_read_no_col", 32'(bus0.collision), 32'd0);

    // Different-address dual write
    drv(0, 1'b0, 1'b1, 1'b1, 6'd6, 8'h12);
    drv(0, 1'b1, 1'b1, 1'b1, 6'd7, 8'h34);
    tick();
    check("diff_no_col", 32'(bus0.collision), 32'd0);
    drv(0, 1'b0, 1'b1, 1'b0, 6'd7, 8'h00);
    drv(0, 1'b1, 1'b1, 1'b0, 6'd6, 8'h00);
    tick();
    idle_all();
    check("diff_rd7", 32'(bus0.q_a), 32'h34);
    check("diff_rd6", 32'(bus0.q_b), 32'h12);

    // Same-address dual write, B wins, output register
    drv(1, 1'b0, 1'b1, 1'b1, 6'd5, 8'hAA);
    drv(1, 1'b1, 1'b1, 1'b1, 6'd5, 8'h55);
    tick();
    idle_all();
    check("col1_pulse", 32'(bus1.collision), 32'd1);
    tick();
    check("col1_pulse_end", 32'(bus1.collision), 32'd0);
    check("col1_q_a_old", 32'(bus1.q_a), 32'h00);
    check("col1_q_b_old", 32'(bus1.q_b), 32'h00);
    check("col1_valid_b", 32'(bus1.valid_b), 32'd1);
    drv(1, 1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    tick();
    idle_all();
    tick();
    check("col1_stored_b", 32'(bus1.q_a), 32'h55);

    // OUT_REG back-to-back reads on port B
    for (int k = 1; k <= 3; k++) begin
      drv(1, 1'b1, 1'b1, 1'b1, 6'(k), 8'(k));
      tick();
    end
    idle_all();
    tick();
    tick();
    drv(1, 1'b1, 1'b1, 1'b0, 6'd1, 8'h00);
    tick();
    check("pipe_e1_no_valid", 32'(bus1.valid_b), 32'd0);
    drv(1, 1'b1, 1'b1, 1'b0, 6'd2, 8'h00);
    tick();
    check("pipe_e2_valid", 32'(bus1.valid_b), 32'd1);
    check("pipe_e2_q", 32'(bus1.q_b), 32'h01);
    drv(1, 1'b1, 1'b1, 1'b0, 6'd3, 8'h00);
    tick();
    check("pipe_e3_valid", 32'(bus1.valid_b), 32'd1);
    check("pipe_e3_q", 32'(bus1.q_b), 32'h02);
    idle_all();
    tick();
    check("pipe_e4_valid", 32'(bus1.valid_b), 32'd1);
    check("pipe_e4_q", 32'(bus1.q_b), 32'h03);
    tick();
    check("pipe_e5_no_valid", 32'(bus1.valid_b), 32'd0);
    check("pipe_e5_hold", 32'(bus1.q_b), 32'h03);

    // Reset mid-clear restarts the sweep
    for (int k = 0; k < 3; k++) begin
      logic [5:0] a;
      a = (k == 0) ? 6'd0 : (k == 1) ? 6'd31 : 6'd63;
      drv(0, 1'b0, 1'b1, 1'b1, a, 8'hFF);
      tick();
      check("fill_ff", 32'(bus0.q_a), 32'hFF);
    end
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_q_a", 32'(bus0.q_a), 32'h00);
    check("rst2_busy", 32'(bus0.busy), 32'd1);
    repeat (30) tick();
    check("mid_clear_busy", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv(0, 1'b0, 1'b1, 1'b1, 6'd0, 8'hEE);
    cnt  = 0;
    anyv = 1'b0;
    while (bus0.busy && cnt < 200) begin
      tick();
      cnt++;
      anyv = anyv | bus0.valid_a;
    end
    idle_all();
    check("restart_busy_cycles", 32'(cnt), 32'd64);
    check("restart_no_valid", 32'(anyv), 32'd0);
    for (int a = 0; a < 64; a++) begin
      drv(0, 1'b0, 1'b1, 1'b0, 6'(a), 8'h00);
      tick();
      check("sweep_valid", 32'(bus0.valid_a), 32'd1);
      check("sweep_zero", 32'(bus0.q_a), 32'h00);
    end
    idle_all();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_tdp_param.md
Name: ram_tdp_param

Overview:
- Parametrised true dual-port synchronous RAM. Next generation of the team's 64x8 dual-port RAM.
- Adds configurable width and depth, and per-port read-during-write mode.
- Adds defined write-collision arbitration with a flag, an optional output pipeline register, and read-valid strobes.
- Adds a reset-triggered memory-clear state machine. Used as shared scratch/buffer storage between two independent masters in one clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
- RDW_MODE_A, 0, port A read-during-write to its own address: 0 = write-first (new data), 1 = read-first (old data), 2 = no-change (q_a holds)
- RDW_MODE_B, 0, same as RDW_MODE_A, for port B
- WR_PRIO_A, 1, same-address dual-write winner: 1 = port A, 0 = port B
- OUT_REG, 0, 1 adds one output pipeline stage on both ports
- CLEAR_ON_RST, 1, 1 = zero all locations after reset

Ports:
- clk, input, 1, single clock, rising edge
- rst, input, 1, synchronous active-high reset
- en_a, input, 1, port A access enable
- we_a, input, 1, port A write enable (qualified by en_a)
- addr_a, input, ADDR_W, port A address
- data_a, input, DATA_W, port A write data
- q_a, output, DATA_W, port A read data
- valid_a, output, 1, q_a updated this cycle
- en_b, input, 1, port B access enable
- we_b, input, 1, port B write enable (qualified by en_b)
- addr_b, input, ADDR_W, port B address
- data_b, input, DATA_W, port B write data
- q_b, output, DATA_W, port B read data
- valid_b, output, 1, q_b updated this cycle
- busy, output, 1, clear in progress; accesses ignored
- collision, output, 1, one-cycle pulse on same-address dual write

Behaviour:
- Reset (rst=1 at an edge):
  - q_a, q_b, valid_a, valid_b, collision and all pipeline registers go to 0.
  - busy goes to CLEAR_ON_RST.
  - Clear FSM enters CLEAR with clr_addr=0 if CLEAR_ON_RST=1, otherwise enters RUN.
  - Memory contents are not reset when CLEAR_ON_RST=0.
- Clear FSM states:
  - CLEAR: each edge with rst=0 writes 0 to mem[clr_addr] and increments clr_addr. The write at clr_addr=DEPTH-1 moves the FSM to RUN and deasserts busy on the same edge. busy is high for exactly DEPTH cycles after rst falls.
  - RUN: normal operation; no exit except reset.
  - rst asserted mid-clear restarts CLEAR at address 0.
- Accepted access = en_x & ~busy. Inputs on non-accepted cycles have no effect; q_x holds and valid_x=0.
- Write: on an accepted access with we_x=1, mem[addr_x] <= data_x at the edge.
- Read latency: 1+OUT_REG cycles from the accepting edge to q_x/valid_x.
  - valid_x pulses exactly once per accepted access, both reads and writes, except a write in no-change mode.
  - q_x holds its last value when valid_x=0.
- Own-port read-during-write (we_x=1):
  - mode 0: q_x = data_x.
  - mode 1: q_x = previous mem[addr_x].
  - mode 2: q_x unchanged and valid_x not asserted.
- Cross-port, same address, one writes and the other reads: the reader always gets the old data. This is deterministic and is required for all modes.
- Both ports write the same address in the same accepted cycle:
  - The WR_PRIO_A winner's data is stored.
  - collision=1 for one cycle, aligned with the edge after the write (latency 1 regardless of OUT_REG).
  - Each port's own read-back follows its RDW mode, using its own data_x.
- Both ports write different addresses: both writes are stored, with no collision.
- Both ports read the same address: both get the same data, with no collision.
- Address width is exact; there is no wrap or out-of-range case.

Decomposition:
- Shared package ram_pkg holds:
  - RDW mode constants RDW_WRITE_FIRST=0, RDW_READ_FIRST=1, RDW_NO_CHANGE=2
  - clear FSM state encoding ST_CLEAR, ST_RUN
- One natural sub-module: ram_tdp_port, instanced twice.
  - Contains per-port read mux, RDW mode selection, optional OUT_REG stage and valid pipeline.
  - The memory array, arbitration and clear FSM stay in the top.

Test Plan:
1. Defaults (8x64, CLEAR_ON_RST=1): pulse rst for 1 cycle. Required: busy high for exactly 64 cycles. Port A reads of addrs 0, 37 and 63 then return 0x00 with valid_a one cycle after each accept. Accesses issued while busy=1 give no valid.
2. Port A writes 0x5A to addr 10 (mode 0) -> q_a=0x5A next cycle. Repeat with RDW_MODE_A=1 and prior content 0x11 -> q_a=0x11. With RDW_MODE_A=2 -> q_a holds and valid_a=0.
3. Same cycle: A writes 0xC3 to addr 20, B reads addr 20 (old content 0x07). Required: q_b=0x07. A subsequent B read of addr 20 returns 0xC3.
4. Same cycle: A writes 0xAA and B writes 0x55, both to addr 5.
   - WR_PRIO_A=1: collision pulses 1 cycle, and a later read returns 0xAA.
   - WR_PRIO_A=0: a later read returns 0x55.
5. OUT_REG=1, back-to-back reads of addrs 1, 2, 3 on port B (contents 0x01, 0x02, 0x03). Required: valid_b high for 3 consecutive cycles starting 2 cycles after the first accept, data in order.
6. Assert rst at clear step 30. Required: clear restarts, busy stays high 64 cycles from rst release, and addrs 0–63 all read 0x00.
